// File: rtl/ama_riscv_imem_dp.sv
// Dual-port instruction memory.
// Port A is a byte-masked write port used by the bootloader / debug loader.
// Port B is the fetch read port: enb=0 stalls every port B register, reads
// are read-first against a same-edge port A write, and an optional output
// register stretches the read latency from 1 to 2 accepted edges.
// The storage array is never reset; only the port B pipeline and the sticky
// address error flag are.
module ama_riscv_imem_dp #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16384,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int OUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W/8-1:0]   wea,
  input  logic [ADDR_W-1:0]     addra,
  input  logic [DATA_W-1:0]     dina,
  input  logic                  enb,
  input  logic [ADDR_W-1:0]     addrb,
  output logic [DATA_W-1:0]     doutb,
  output logic                  doutb_vld,
  output logic                  addr_err
);

  localparam int NBYTES = DATA_W / 8;
  // One extra bit so DEPTH itself is representable even when it is a power of 2.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              a_ok;
  logic              b_ok;
  logic              a_wr;
  logic [DATA_W-1:0] rd_p0;
  logic              vld_p0;

  // True when a word address falls inside the populated array.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_X);
  endfunction

  assign a_ok = in_range(addra);
  assign b_ok = in_range(addrb);
  assign a_wr = |wea;

  // Port A byte-masked write; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (a_wr && a_ok) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wea[i]) mem[addra][i*8 +: 8] <= dina[i*8 +: 8];
      end
    end
  end

  // ---- stage p0: array read, read-first against a same-edge port A write ----
  // Out-of-range reads still complete, returning zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_p0  <= '0;
      vld_p0 <= 1'b0;
    end else if (enb) begin
      rd_p0  <= b_ok ? mem[addrb] : '0;
      vld_p0 <= 1'b1;
    end
  end

  // Sticky flag for any access past the end of the array; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else if ((enb && !b_ok) || (a_wr && !a_ok)) begin
      addr_err <= 1'b1;
    end
  end

  // ---- stage p1: optional output register, advancing only on enb ----
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] dout_p1;
      logic              vld_p1;

      // Output register shares the port B stall so a pending p0 word is never lost.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_p1 <= '0;
          vld_p1  <= 1'b0;
        end else if (enb) begin
          dout_p1 <= rd_p0;
          vld_p1  <= vld_p0;
        end
      end

      assign doutb     = dout_p1;
      assign doutb_vld = vld_p1;
    end else begin : g_noreg
      assign doutb     = rd_p0;
      assign doutb_vld = vld_p0;
    end
  endgenerate

endmodule

// File: tb/tb_ama_riscv_imem_dp.sv
// Bench for ama_riscv_imem_dp: one instance with DEPTH=1000 / OUT_REG=0 and
// one with DEPTH=16384 / OUT_REG=1, sharing clock and reset.
module tb_ama_riscv_imem_dp;

  logic clk;
  logic rst;

  // u0: DEPTH=1000, latency 1
  logic [3:0]  wea0;
  logic [9:0]  addra0;
  logic [31:0] dina0;
  logic        enb0;
  logic [9:0]  addrb0;
  logic [31:0] doutb0;
  logic        vld0;
  logic        err0;

  // u1: DEPTH=16384, latency 2
  logic [3:0]  wea1;
  logic [13:0] addra1;
  logic [31:0] dina1;
  logic        enb1;
  logic [13:0] addrb1;
  logic [31:0] doutb1;
  logic        vld1;
  logic        err1;

  int checks;
  int errors;

  // Scoreboards and reference memories
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] ref0 [int];
  logic [31:0] ref1 [int];
  logic [31:0] lastexp0, lastexp1;
  logic        lastv0, lastv1, experr0;

  ama_riscv_imem_dp #(.DATA_W(32), .DEPTH(1000), .ADDR_W(10), .OUT_REG(0)) u0 (
    .clk(clk), .rst(rst), .wea(wea0), .addra(addra0), .dina(dina0),
    .enb(enb0), .addrb(addrb0), .doutb(doutb0), .doutb_vld(vld0), .addr_err(err0)
  );

  ama_riscv_imem_dp #(.DATA_W(32), .DEPTH(16384), .ADDR_W(14), .OUT_REG(1)) u1 (
    .clk(clk), .rst(rst), .wea(wea1), .addra(addra1), .dina(dina1),
    .enb(enb1), .addrb(addrb1), .doutb(doutb1), .doutb_vld(vld1), .addr_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] di,
                                        input logic [3:0] we);
    logic [31:0] w;
    w = old;
    for (int i = 0; i < 4; i++) if (we[i]) w[i*8 +: 8] = di[i*8 +: 8];
    return w;
  endfunction

  // One edge on u0; expected read pushed at drive time (read-first), popped after the edge.
  task automatic drv0(input logic en, input logic [9:0] ab, input logic [3:0] we,
                      input logic [9:0] aa, input logic [31:0] di);
    enb0 = en; addrb0 = ab; wea0 = we; addra0 = aa; dina0 = di;
    if (en) begin
      if (ab < 10'd1000) q0.push_back(ref0.exists(int'(ab)) ? ref0[int'(ab)] : 32'h0);
      else begin
        q0.push_back(32'h0);
        experr0 = 1'b1;
      end
    end
    if (we != 4'h0) begin
      if (aa < 10'd1000)
        ref0[int'(aa)] = merge(ref0.exists(int'(aa)) ? ref0[int'(aa)] : 32'h0, di, we);
      else experr0 = 1'b1;
    end
    @(posedge clk); #1;
    if (en) begin
      lastexp0 = q0.pop_front();
      lastv0   = 1'b1;
    end
    enb0 = 1'b0; wea0 = 4'h0;
  endtask

  // One edge on u1; output reflects the read accepted on the previous accepted edge.
  task automatic drv1(input logic en, input logic [13:0] ab, input logic [3:0] we,
                      input logic [13:0] aa, input logic [31:0] di);
    enb1 = en; addrb1 = ab; wea1 = we; addra1 = aa; dina1 = di;
    if (en) q1.push_back(ref1.exists(int'(ab)) ? ref1[int'(ab)] : 32'h0);
    if (we != 4'h0)
      ref1[int'(aa)] = merge(ref1.exists(int'(aa)) ? ref1[int'(aa)] : 32'h0, di, we);
    @(posedge clk); #1;
    if (en && q1.size() >= 2) begin
      lastexp1 = q1.pop_front();
      lastv1   = 1'b1;
    end
    enb1 = 1'b0; wea1 = 4'h0;
  endtask

  task automatic clear_model();
    q0.delete(); q1.delete();
    lastexp0 = 32'h0; lastexp1 = 32'h0;
    lastv0 = 1'b0; lastv1 = 1'b0; experr0 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    checks++; if (doutb0 !== 32'h0) begin errors++; $display("FAIL reset_doutb0 got %h want 0", doutb0); end
    checks++; if (vld0 !== 1'b0)    begin errors++; $display("FAIL reset_vld0 got %b want 0", vld0); end
    checks++; if (err0 !== 1'b0)    begin errors++; $display("FAIL reset_err0 got %b want 0", err0); end
    checks++; if (doutb1 !== 32'h0) begin errors++; $display("FAIL reset_doutb1 got %h want 0", doutb1); end
    checks++; if (vld1 !== 1'b0)    begin errors++; $display("FAIL reset_vld1 got %b want 0", vld1); end
    checks++; if (err1 !== 1'b0)    begin errors++; $display("FAIL reset_err1 got %b want 0", err1); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    drv0(1'b0, 10'd0, 4'hF, 10'd5, 32'hDEADBEEF);
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL wr_only_vld got %b want 0", vld0); end
    drv0(1'b1, 10'd5, 4'h0, 10'd0, 32'h0);
    checks++; if (doutb0 !== 32'hDEADBEEF) begin errors++; $display("FAIL read5 got %h want deadbeef", doutb0); end
    checks++; if (vld0 !== 1'b1) begin errors++; $display("FAIL read5_vld got %b want 1", vld0); end
  endtask

  task automatic test_byte_enable();
    drv0(1'b0, 10'd0, 4'hF, 10'd7, 32'h11223344);
    drv0(1'b0, 10'd0, 4'b0101, 10'd7, 32'hAABBCCDD);
    drv0(1'b1, 10'd7, 4'h0, 10'd0, 32'h0);
    checks++; if (doutb0 !== 32'h11BB33DD) begin errors++; $display("FAIL byte_en got %h want 11bb33dd", doutb0); end
  endtask

  task automatic test_read_first();
    drv0(1'b0, 10'd0, 4'hF, 10'd9, 32'h2);
    drv0(1'b1, 10'd9, 4'hF, 10'd9, 32'h1);
    checks++; if (doutb0 !== 32'h2) begin errors++; $display("FAIL read_first_old got %h want 2", doutb0); end
    drv0(1'b1, 10'd9, 4'h0, 10'd0, 32'h0);
    checks++; if (doutb0 !== 32'h1) begin errors++; $display("FAIL read_first_new got %h want 1", doutb0); end
  endtask

  task automatic test_stall_lat1();
    for (int i = 0; i < 3; i++) begin
      drv0(1'b0, 10'd5, 4'h0, 10'd0, 32'h0);
      checks++; if (doutb0 !== lastexp0 || vld0 !== lastv0)
        begin errors++; $display("FAIL stall0 got %h/%b want %h/%b", doutb0, vld0, lastexp0, lastv0); end
    end
  endtask

  task automatic test_out_of_range();
    drv0(1'b0, 10'd0, 4'hF, 10'd23, 32'hCAFE0023);
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL oor_pre_err got %b want 0", err0); end
    drv0(1'b1, 10'd1000, 4'h0, 10'd0, 32'h0);
    checks++; if (doutb0 !== 32'h0) begin errors++; $display("FAIL oor_read got %h want 0", doutb0); end
    checks++; if (vld0 !== 1'b1)    begin errors++; $display("FAIL oor_vld got %b want 1", vld0); end
    checks++; if (err0 !== 1'b1)    begin errors++; $display("FAIL oor_err got %b want 1", err0); end
    repeat (3) drv0(1'b0, 10'd0, 4'h0, 10'd0, 32'h0);
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL oor_sticky got %b want 1", err0); end
    drv0(1'b0, 10'd0, 4'hF, 10'd1023, 32'h55555555);
    drv0(1'b1, 10'd23, 4'h0, 10'd0, 32'h0);
    checks++; if (doutb0 !== 32'hCAFE0023) begin errors++; $display("FAIL oor_no_alias got %h want cafe0023", doutb0); end
    checks++; if (err0 !== experr0) begin errors++; $display("FAIL oor_err_hold got %b want %b", err0, experr0); end
  endtask

  task automatic test_back_to_back_lat1();
    logic en; logic [3:0] we;
    for (int a = 100; a < 116; a++) drv0(1'b0, 10'd0, 4'hF, 10'(a), $urandom);
    for (int i = 0; i < 40; i++) begin
      en = 1'($urandom_range(0, 1));
      we = 4'($urandom_range(0, 15));
      drv0(en, 10'(100 + $urandom_range(0, 15)), we, 10'(100 + $urandom_range(0, 15)), $urandom);
      checks++; if (doutb0 !== lastexp0 || vld0 !== lastv0)
        begin errors++; $display("FAIL b2b0[%0d] got %h/%b want %h/%b", i, doutb0, vld0, lastexp0, lastv0); end
    end
  endtask

  task automatic test_out_reg_stall();
    logic        en_t [7];
    logic [13:0] ab_t [7];
    en_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ab_t = '{14'd1, 14'd2, 14'd3, 14'd4, 14'd5, 14'd3, 14'd3};
    drv1(1'b0, 14'd0, 4'hF, 14'd1, 32'hA1A1A1A1);
    drv1(1'b0, 14'd0, 4'hF, 14'd2, 32'hB2B2B2B2);
    drv1(1'b0, 14'd0, 4'hF, 14'd3, 32'hC3C3C3C3);
    checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL oreg_idle_vld got %b want 0", vld1); end
    for (int i = 0; i < 7; i++) begin
      drv1(en_t[i], ab_t[i], 4'h0, 14'd0, 32'h0);
      checks++; if (doutb1 !== lastexp1 || vld1 !== lastv1)
        begin errors++; $display("FAIL oreg[%0d] got %h/%b want %h/%b", i, doutb1, vld1, lastexp1, lastv1); end
    end
    checks++; if (doutb1 !== 32'hC3C3C3C3) begin errors++; $display("FAIL oreg_last got %h want c3c3c3c3", doutb1); end
  endtask

  task automatic test_back_to_back_lat2();
    logic en; logic [3:0] we;
    for (int a = 16; a < 32; a++) drv1(1'b0, 14'd0, 4'hF, 14'(a), $urandom);
    for (int i = 0; i < 40; i++) begin
      en = 1'($urandom_range(0, 1));
      we = 4'($urandom_range(0, 15));
      drv1(en, 14'(16 + $urandom_range(0, 15)), we, 14'(16 + $urandom_range(0, 15)), $urandom);
      checks++; if (doutb1 !== lastexp1 || vld1 !== lastv1)
        begin errors++; $display("FAIL b2b1[%0d] got %h/%b want %h/%b", i, doutb1, vld1, lastexp1, lastv1); end
    end
  endtask

  task automatic test_reset_midstream();
    drv1(1'b1, 14'd1, 4'h0, 14'd0, 32'h0);
    drv0(1'b1, 10'd5, 4'h0, 10'd0, 32'h0);
    drv0(1'b1, 10'd7, 4'h0, 10'd0, 32'h0);
    rst = 1'b1;
    #1;
    clear_model();
    checks++; if (doutb0 !== 32'h0 || vld0 !== 1'b0)
      begin errors++; $display("FAIL midrst_u0 got %h/%b want 0/0", doutb0, vld0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL midrst_err0 got %b want 0", err0); end
    checks++; if (doutb1 !== 32'h0 || vld1 !== 1'b0)
      begin errors++; $display("FAIL midrst_u1 got %h/%b want 0/0", doutb1, vld1); end
    @(posedge clk); #1;
    rst = 1'b0;
    drv0(1'b1, 10'd5, 4'h0, 10'd0, 32'h0);
    checks++; if (doutb0 !== 32'hDEADBEEF || vld0 !== 1'b1)
      begin errors++; $display("FAIL post_rst_mem got %h/%b want deadbeef/1", doutb0, vld0); end
    drv1(1'b1, 14'd1, 4'h0, 14'd0, 32'h0);
    checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL post_rst_vld1 got %b want 0", vld1); end
    drv1(1'b1, 14'd2, 4'h0, 14'd0, 32'h0);
    checks++; if (doutb1 !== 32'hA1A1A1A1 || vld1 !== 1'b1)
      begin errors++; $display("FAIL post_rst_u1 got %h/%b want a1a1a1a1/1", doutb1, vld1); end
    drv0(1'b0, 10'd0, 4'h3, 10'd1023, 32'h12345678);
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL wr_oor_err got %b want 1", err0); end
    drv0(1'b1, 10'd5, 4'h0, 10'd0, 32'h0);
    checks++; if (doutb0 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_oor_dropped got %h want deadbeef", doutb0); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    wea0 = 4'h0; addra0 = '0; dina0 = '0; enb0 = 1'b0; addrb0 = '0;
    wea1 = 4'h0; addra1 = '0; dina1 = '0; enb1 = 1'b0; addrb1 = '0;
    clear_model();
    test_reset();
    test_write_read();
    test_byte_enable();
    test_read_first();
    test_stall_lat1();
    test_out_of_range();
    test_back_to_back_lat1();
    test_out_reg_stall();
    test_back_to_back_lat2();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
